// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared types and limits for the bit-serial subtractor.
//   sub_state_t : controller states (IDLE, SHIFT, DONE), 2-bit encoding
//   MIN_WIDTH / MAX_WIDTH : supported operand width range
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// One-bit full subtractor computing a - b - bin, assembled from two
// half-subtractor stages and an OR, the same shape as the adder cells.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // first half subtractor: a - b
    assign d1 = a ^ b;
    assign b1 = ~a & b;

    // second half subtractor: (a - b) - bin
    assign d  = d1 ^ bin;
    assign b2 = ~d1 & bin;

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial a - b, LSB first, one bit per clock through a single
// full_subtractor cell and a borrow flip-flop. Start/done handshake;
// results hold until the next operation completes.
// Parameters:
//   WIDTH     operand/result width, 2..32
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active-high
//   start     request pulse, honoured only in IDLE
//   a, b      operands, captured on the accepting edge
//   busy      high while not IDLE
//   done      one-cycle pulse when results become valid
//   diff      (a - b) mod 2^WIDTH
//   borrow    unsigned borrow (a < b)
//   overflow  signed overflow of a - b
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    sub_state_t       state;
    sub_state_t       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             bff;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bout;
    logic             last_bit;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bff),
        .d    (d),
        .bout (bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // difference bits enter at the MSB so the LSB-first stream ends aligned
    assign res_next = {d, res_sr[WIDTH-1:1]};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            bff      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        // sign bits are shifted out of the operand registers,
                        // so keep copies for the overflow flag
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        bff   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bff    <= bout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff     <= res_next;
                        borrow   <= bout;
                        // d is the result MSB on the last bit
                        overflow <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t exp_r;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        r.d  = x - y;
        r.br = (x < y);
        r.ov = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        sb.push_back(model(x, y));
    endtask

    // ticks until done is seen; edges = -1 if the budget runs out
    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < budget) begin
            tick();
            edges++;
        end
        if (done !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        n_checks++;
        if ({busy, done, diff, borrow, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%0b done=%0b diff=%0d borrow=%0b ovf=%0b, expected all 0",
                     busy, done, diff, borrow, overflow);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b done=%0b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int edges;
        int busy_cnt;
        a = 8'd200; b = 8'd55; start = 1'b1;
        push(a, b);
        tick();
        start = 1'b0; a = 8'd3; b = 8'd250;  // operands must already be latched
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        edges = 0;
        while (done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d edges, expected 8", edges);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if ({diff, borrow, overflow} !== {exp_r.d, exp_r.br, exp_r.ov}) begin
            n_fail++;
            $display("FAIL basic_result: diff=%0d borrow=%0b ovf=%0b, expected diff=%0d borrow=%0b ovf=%0b",
                     diff, borrow, overflow, exp_r.d, exp_r.br, exp_r.ov);
        end
        tick();
        if (busy === 1'b1) busy_cnt++;
        n_checks++;
        if (busy_cnt !== 9 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy cycles=%0d done=%0b, expected 9 cycles and done 0", busy_cnt, done);
        end
    endtask

    task automatic test_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
        int edges;
        a = x; b = y; start = 1'b1;
        push(x, y);
        tick();
        start = 1'b0;
        wait_done(20, edges);
        n_checks++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d edges, expected 8", name, edges);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if ({diff, borrow, overflow} !== {exp_r.d, exp_r.br, exp_r.ov}) begin
            n_fail++;
            $display("FAIL %s_result: diff=%0h borrow=%0b ovf=%0b, expected diff=%0h borrow=%0b ovf=%0b",
                     name, diff, borrow, overflow, exp_r.d, exp_r.br, exp_r.ov);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int edges;
        a = 8'd9; b = 8'd3; start = 1'b1;
        push(a, b);
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'd100; b = 8'd1; start = 1'b1;   // mid-SHIFT request
        tick();
        start = 1'b0;
        wait_done(20, edges);
        n_checks++;
        if (edges !== 5) begin
            n_fail++;
            $display("FAIL ignore_latency: done after %0d more edges, expected 5", edges);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if (diff !== exp_r.d || borrow !== exp_r.br) begin
            n_fail++;
            $display("FAIL ignore_result: diff=%0d borrow=%0b, expected diff=%0d borrow=%0b",
                     diff, borrow, exp_r.d, exp_r.br);
        end
        start = 1'b1;                          // request during DONE, held into IDLE
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd6) begin
            n_fail++;
            $display("FAIL ignore_done_start: busy=%0b done=%0b diff=%0d, expected 0 0 6", busy, done, diff);
        end
        push(a, b);
        tick();                                // accepted in the first IDLE cycle
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || diff !== 8'd6) begin
            n_fail++;
            $display("FAIL ignore_restart: busy=%0b diff=%0d, expected busy 1 diff held 6", busy, diff);
        end
        wait_done(20, edges);
        n_checks++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL ignore_second_latency: done after %0d edges, expected 8", edges);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if (diff !== exp_r.d || borrow !== exp_r.br) begin
            n_fail++;
            $display("FAIL ignore_second_result: diff=%0d borrow=%0b, expected diff=%0d borrow=%0b",
                     diff, borrow, exp_r.d, exp_r.br);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        a = 8'd50; b = 8'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, diff, borrow, overflow} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%0b done=%0b diff=%0d borrow=%0b ovf=%0b, expected all 0",
                     busy, done, diff, borrow, overflow);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: %0d done pulses, expected 0", seen);
        end
        test_op("after_rst", 8'd7, 8'd7);
    endtask

    task automatic test_back_to_back();
        int edges;
        int seen;
        a = 8'd1; b = 8'd2; start = 1'b1;      // start held throughout
        push(a, b);
        tick();
        for (int op = 0; op < 3; op++) begin
            if (op == 1) begin
                tick(); tick();
                a = 8'hAA;                     // disturb the minuend mid-SHIFT
                tick();
                a = 8'd1;
                wait_done(20, edges);
                edges = (edges < 0) ? -1 : edges + 3;
            end else begin
                wait_done(20, edges);
            end
            n_checks++;
            if (edges !== 8) begin
                n_fail++;
                $display("FAIL b2b_latency op%0d: done after %0d edges, expected 8", op, edges);
            end
            exp_r = sb.pop_front();
            n_checks++;
            if ({diff, borrow, overflow} !== {exp_r.d, exp_r.br, exp_r.ov}) begin
                n_fail++;
                $display("FAIL b2b_result op%0d: diff=%0h borrow=%0b ovf=%0b, expected diff=%0h borrow=%0b ovf=%0b",
                         op, diff, borrow, overflow, exp_r.d, exp_r.br, exp_r.ov);
            end
            if (op == 2) start = 1'b0;
            tick();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle op%0d: busy=%0b, expected 0", op, busy);
            end
            if (op < 2) push(a, b);
            tick();                            // next accept, 10 cycles after previous
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1 || done === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL b2b_stop: %0d busy/done cycles after start dropped, expected 0", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_op("5_minus_10", 8'd5, 8'd10);
        test_op("80_minus_01", 8'h80, 8'h01);
        test_op("7f_minus_ff", 8'h7F, 8'hFF);
        test_ignored_start();
        test_reset_mid_shift();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
